// File: rtl/game_pkg.sv
// Shared types and constants for the Pacman game-flow controller.
package game_pkg;

  typedef enum logic [2:0] {
    RES    = 3'd0,
    LOAD   = 3'd1,
    PLAY   = 3'd2,
    DYING  = 3'd3,
    CLEAR  = 3'd4,
    OVER   = 3'd5,
    WIN    = 3'd6,
    PAUSED = 3'd7
  } game_state_t;

  localparam logic [1:0] SCR_PAUSE = 2'b00;
  localparam logic [1:0] SCR_PLAY  = 2'b01;
  localparam logic [1:0] SCR_OVER  = 2'b10;
  localparam logic [1:0] SCR_WIN   = 2'b11;

  localparam logic [7:0] KEY_ENTER_DEF = 8'h28;
  localparam logic [7:0] KEY_PAUSE_DEF = 8'h13;

endpackage

// File: rtl/key_edge.sv
// One-cycle press detector for a single USB keycode; a held key
// yields exactly one hit.
module key_edge #(
  parameter logic [7:0] KEY = 8'h28
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] key_i,
  output logic       hit_o
);

  logic [7:0] prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) prev_q <= '0;
    else       prev_q <= key_i;
  end

  assign hit_o = (key_i == KEY) && (prev_q != KEY);

endmodule

// File: rtl/game_flow_ctrl.sv
// Game-flow sequencer: lives, levels, death/clear delays, round reset.
// Optional pause state enabled by defining GAME_FLOW_PAUSE_EN.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int         NUM_LEVELS   = 3,
  parameter int         LIVES        = 3,
  parameter int         DELAY_FRAMES = 60,
  parameter logic [7:0] KEY_ENTER    = KEY_ENTER_DEF,
  parameter logic [7:0] KEY_PAUSE    = KEY_PAUSE_DEF,
  localparam int LVL_W  = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
  localparam int LIFE_W = $clog2(LIVES + 1)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [7:0]        keycode,
  input  logic              frame_tick,
  input  logic              over,
  input  logic              win,
  output logic              round_rst,
  output logic [1:0]        screen,
  output logic [LVL_W-1:0]  level_idx,
  output logic [LIFE_W-1:0] lives_left,
  output logic              freeze
);

  localparam int CNT_W = $clog2(DELAY_FRAMES + 1);

  localparam logic [LIFE_W-1:0] LIVES_L  = LIFE_W'(LIVES);
  localparam logic [LIFE_W-1:0] ONE_L    = LIFE_W'(1);
  localparam logic [LVL_W-1:0]  LAST_LVL = LVL_W'(NUM_LEVELS - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DELAY_FRAMES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DELAY_FRAMES);

  game_state_t       state_q, state_d;
  logic [LIFE_W-1:0] lives_q, lives_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              enter_hit;

  key_edge #(.KEY(KEY_ENTER)) u_enter (
    .clk_i (Clk),
    .rst_i (Reset),
    .key_i (keycode),
    .hit_o (enter_hit)
  );

`ifdef GAME_FLOW_PAUSE_EN
  logic pause_hit;

  key_edge #(.KEY(KEY_PAUSE)) u_pause (
    .clk_i (Clk),
    .rst_i (Reset),
    .key_i (keycode),
    .hit_o (pause_hit)
  );
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= RES;
      lives_q <= LIVES_L;
      level_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    case (state_q)
      RES: begin
        lives_d = LIVES_L;
        level_d = '0;
        state_d = LOAD;
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = PLAY;
      end
      PLAY: begin
        // over outranks win, and both outrank a pause press
        if (over) begin
          cnt_d = '0;
          if (lives_q > ONE_L) begin
            lives_d = lives_q - ONE_L;
            state_d = DYING;
          end else begin
            lives_d = '0;
            state_d = OVER;
          end
        end else if (win) begin
          cnt_d   = '0;
          state_d = (level_q == LAST_LVL) ? WIN : CLEAR;
        end
`ifdef GAME_FLOW_PAUSE_EN
        else if (pause_hit) begin
          state_d = PAUSED;
        end
`endif
      end
      DYING, CLEAR: begin
        if (frame_tick) begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = LOAD;
            if (state_q == CLEAR) level_d = level_q + 1'b1;
          end
        end
      end
      OVER, WIN: begin
        if (enter_hit) state_d = RES;
      end
`ifdef GAME_FLOW_PAUSE_EN
      PAUSED: begin
        if (pause_hit) state_d = PLAY;
      end
`endif
      default: state_d = RES;
    endcase
  end

  always_comb begin
    round_rst = 1'b0;
    freeze    = 1'b1;
    screen    = SCR_PLAY;
    case (state_q)
      RES, LOAD: round_rst = 1'b1;
      PLAY:      freeze    = 1'b0;
      OVER:      screen    = SCR_OVER;
      WIN:       screen    = SCR_WIN;
`ifdef GAME_FLOW_PAUSE_EN
      PAUSED:    screen    = SCR_PAUSE;
`endif
      default: ;
    endcase
  end

  assign level_idx  = level_q;
  assign lives_left = lives_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed scenarios plus random play
// checked every cycle against a counter-based behavioural model.
module tb_game_flow_ctrl;

  localparam int         NL = 3;
  localparam int         LV = 3;
  localparam int         DF = 4;
  localparam logic [7:0] KE = 8'h28;

  logic       Clk = 1'b0;
  logic       clk_en = 1'b1;
  logic       Reset = 1'b1;
  logic [7:0] keycode = 8'h00;
  logic       frame_tick = 1'b0;
  logic       over = 1'b0;
  logic       win = 1'b0;
  logic       round_rst;
  logic [1:0] screen;
  logic [1:0] level_idx;
  logic [1:0] lives_left;
  logic       freeze;

  int total = 0;
  int bad = 0;

  // model: pending round-reset cycles, remaining delay ticks, end code
  int         m_rst = 2;
  int         m_lives = LV;
  int         m_level = 0;
  int         m_wait = 0;
  int         m_lvlup = 0;
  int         m_end = 0;
  logic [7:0] m_prev = 8'h00;

  game_flow_ctrl #(
    .NUM_LEVELS   (NL),
    .LIVES        (LV),
    .DELAY_FRAMES (DF)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .keycode    (keycode),
    .frame_tick (frame_tick),
    .over       (over),
    .win        (win),
    .round_rst  (round_rst),
    .screen     (screen),
    .level_idx  (level_idx),
    .lives_left (lives_left),
    .freeze     (freeze)
  );

  initial forever begin
    #5;
    if (clk_en) Clk = ~Clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit hit;
    if (Reset) begin
      m_rst = 2; m_lives = LV; m_level = 0;
      m_wait = 0; m_lvlup = 0; m_end = 0; m_prev = 8'h00;
      return;
    end
    hit = (keycode == KE) && (m_prev != KE);
    m_prev = keycode;
    if (m_rst == 2) begin
      m_lives = LV; m_level = 0; m_rst = 1;
    end else if (m_rst == 1) begin
      m_rst = 0;
    end else if (m_end != 0) begin
      if (hit) begin m_end = 0; m_rst = 2; end
    end else if (m_wait > 0) begin
      if (frame_tick) begin
        m_wait--;
        if (m_wait == 0) begin
          m_rst = 1;
          if (m_lvlup != 0) m_level++;
        end
      end
    end else if (over) begin
      if (m_lives > 1) begin
        m_lives--; m_wait = DF; m_lvlup = 0;
      end else begin
        m_lives = 0; m_end = 2;
      end
    end else if (win) begin
      if (m_level == NL - 1) m_end = 3;
      else begin m_wait = DF; m_lvlup = 1; end
    end
  endtask

  initial forever begin
    @(posedge Clk or posedge Reset);
    model_step();
  end

  initial forever begin
    int e_scr;
    @(negedge Clk);
    e_scr = (m_rst == 0 && m_end != 0) ? m_end : 1;
    chk("round_rst", int'(round_rst), (m_rst > 0) ? 1 : 0);
    chk("freeze", int'(freeze),
        (m_rst == 0 && m_end == 0 && m_wait == 0) ? 0 : 1);
    chk("screen", int'(screen), e_scr);
    chk("lives_left", int'(lives_left), m_lives);
    chk("level_idx", int'(level_idx), m_level);
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1; step();
      frame_tick = 1'b0; step();
    end
  endtask

  initial begin
    int rr_cnt;
    int k;
    repeat (3) step();
    Reset = 1'b0;
    chk("t1_res_rr", int'(round_rst), 1);
    chk("t1_res_lives", int'(lives_left), 3);
    step();
    chk("t1_load_rr", int'(round_rst), 1);
    step();
    chk("t1_play_rr", int'(round_rst), 0);
    chk("t1_play_frz", int'(freeze), 0);
    chk("t1_play_lvl", int'(level_idx), 0);

    over = 1'b1; step(); over = 1'b0;
    chk("t2_lives", int'(lives_left), 2);
    chk("t2_frz", int'(freeze), 1);
    ticks(3);
    chk("t2_frz3", int'(freeze), 1);
    chk("t2_rr3", int'(round_rst), 0);
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    chk("t2_load_rr", int'(round_rst), 1);
    step();
    chk("t2_play_frz", int'(freeze), 0);
    chk("t2_play_lvl", int'(level_idx), 0);

    win = 1'b1; step(); win = 1'b0;
    ticks(2);
    clk_en = 1'b0;
    #2 Reset = 1'b1;
    #1;
    chk("t3_async_rr", int'(round_rst), 1);
    chk("t3_async_frz", int'(freeze), 1);
    chk("t3_async_lives", int'(lives_left), 3);
    chk("t3_async_scr", int'(screen), 1);
    clk_en = 1'b1;
    step(); step();
    Reset = 1'b0;
    step(); step();

    for (int lv = 0; lv < 2; lv++) begin
      win = 1'b1; step(); win = 1'b0;
      chk("t4_clear_frz", int'(freeze), 1);
      ticks(3);
      frame_tick = 1'b1; step(); frame_tick = 1'b0;
      chk("t4_level", int'(level_idx), lv + 1);
      step();
    end
    win = 1'b1; step(); win = 1'b0;
    chk("t4_win_scr", int'(screen), 3);
    keycode = KE;
    rr_cnt = 0;
    repeat (10) begin
      step();
      rr_cnt += int'(round_rst);
    end
    keycode = 8'h00;
    chk("t4_rr_cycles", rr_cnt, 2);
    chk("t4_lives", int'(lives_left), 3);
    chk("t4_level0", int'(level_idx), 0);

    repeat (2) begin
      over = 1'b1; step(); over = 1'b0;
      ticks(DF);
      step();
    end
    chk("t5_lives1", int'(lives_left), 1);
    over = 1'b1; win = 1'b1; step(); over = 1'b0; win = 1'b0;
    chk("t5_over_scr", int'(screen), 2);
    chk("t5_over_lives", int'(lives_left), 0);
    keycode = 8'h13; step();
    chk("t5_pause_ign", int'(screen), 2);
    keycode = KE; step(); keycode = 8'h00;
    chk("t5_enter_rr", int'(round_rst), 1);
    step(); step();

    repeat (4000) begin
      over = ($urandom_range(0, 19) == 0);
      win = ($urandom_range(0, 24) == 0);
      frame_tick = $urandom_range(0, 1) == 1;
      k = $urandom_range(0, 5);
      case (k)
        0, 1: keycode = 8'h00;
        2, 3: keycode = KE;
        4: keycode = 8'h13;
        default: keycode = 8'h04;
      endcase
      Reset = ($urandom_range(0, 599) == 0);
      step();
    end
    Reset = 1'b0;
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
